// File: rtl/tag_ram_ctrl_if.sv
// rtl/tag_ram_ctrl_if.sv - request/response bundle between cache front-end and tag controller
interface tag_ram_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 12
);
    logic                     req_valid;
    logic                     req_ready;
    logic [TWIDTH+AWIDTH-1:0] req_addr;
    logic                     req_write;
    logic                     resp_valid;
    logic                     resp_hit;
    logic                     resp_evict;
    logic [TWIDTH-1:0]        resp_evict_tag;

    modport master (
        output req_valid, req_addr, req_write,
        input  req_ready, resp_valid, resp_hit, resp_evict, resp_evict_tag
    );

    modport slave (
        input  req_valid, req_addr, req_write,
        output req_ready, resp_valid, resp_hit, resp_evict, resp_evict_tag
    );
endinterface

// File: rtl/tag_ram_ctrl.sv
// rtl/tag_ram_ctrl.sv - tag RAM lookup/update controller with post-reset clear sweep
module tag_ram_ctrl #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 12,
    localparam int DWIDTH = TWIDTH + 2
) (
    input  logic              clock,
    input  logic              reset,
    tag_ram_ctrl_if.slave     bus,
    output logic              init_done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);
    typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} state_t;

    state_t            state;
    logic [AWIDTH-1:0] clr_cnt;
    logic [TWIDTH-1:0] cap_tag;
    logic [AWIDTH-1:0] cap_idx;
    logic              cap_write;

    logic              st_valid;
    logic              st_dirty;
    logic [TWIDTH-1:0] st_tag;
    logic              hit;
    logic              evict;
    logic              accept;

    assign st_valid = ram_dout[DWIDTH-1];
    assign st_dirty = ram_dout[DWIDTH-2];
    assign st_tag   = ram_dout[TWIDTH-1:0];
    assign hit      = st_valid && (st_tag == cap_tag);
    assign evict    = !hit && st_valid && st_dirty;
    assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;

    // In IDLE the request index goes straight to the RAM so the lookup address
    // is latched on the accept edge and the entry is ready during LOOKUP.
    always_comb begin
        ram_addr = cap_idx;
        ram_din  = '0;
        ram_we   = 1'b0;
        case (state)
            INIT: begin
                ram_addr = clr_cnt;
                ram_we   = 1'b1;
            end
            IDLE: ram_addr = bus.req_addr[AWIDTH-1:0];
            LOOKUP: begin
                // Every write case stores dirty = access type: a miss installs
                // {1, write, tag}; a clean write hit installs {1, 1, tag}.
                ram_we  = !hit || (cap_write && !st_dirty);
                ram_din = {1'b1, cap_write, cap_tag};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= INIT;
            clr_cnt            <= '0;
            cap_tag            <= '0;
            cap_idx            <= '0;
            cap_write          <= 1'b0;
            init_done          <= 1'b0;
            bus.req_ready      <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_hit       <= 1'b0;
            bus.resp_evict     <= 1'b0;
            bus.resp_evict_tag <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + AWIDTH'(1);
                    if (clr_cnt == '1) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        cap_tag       <= bus.req_addr[TWIDTH+AWIDTH-1:AWIDTH];
                        cap_idx       <= bus.req_addr[AWIDTH-1:0];
                        cap_write     <= bus.req_write;
                        bus.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    bus.resp_hit       <= hit;
                    bus.resp_evict     <= evict;
                    bus.resp_evict_tag <= evict ? st_tag : '0;
                    bus.resp_valid     <= 1'b1;
                    state              <= RESP;
                end
                RESP: begin
                    // Ready rises with the return to IDLE so the next accept
                    // can land on the very next edge.
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_tag_ram_ctrl.sv
// tb/tb_tag_ram_ctrl.sv - randomized self-checking bench for tag_ram_ctrl with a behavioural tag store
module tb_tag_ram_ctrl;
    localparam int AWIDTH = 3;
    localparam int TWIDTH = 12;
    localparam int DWIDTH = TWIDTH + 2;
    localparam int DEPTH  = 1 << AWIDTH;

    logic              clock;
    logic              reset;
    logic              init_done;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;

    tag_ram_ctrl_if #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) bus ();

    tag_ram_ctrl #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read single-port tag RAM
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] rd_addr;
    int                wr_total;
    logic [DWIDTH-1:0] last_din;
    assign ram_dout = mem[rd_addr];

    always @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            last_din      <= ram_din;
            wr_total      <= wr_total + 1;
        end
        rd_addr <= ram_addr;
    end

    // Reference tag store
    bit          m_valid [DEPTH];
    bit          m_dirty [DEPTH];
    logic [11:0] m_tag   [DEPTH];

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = '0;
        end
    endtask

    // Called at the negedge following the last reset edge.
    task automatic check_init();
        reset = 1'b0;
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_hit", 32'(bus.resp_hit), 0);
        check("rst_resp_evict", 32'(bus.resp_evict), 0);
        check("rst_evict_tag", 32'(bus.resp_evict_tag), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clock);
            check("clr_we", 32'(ram_we), 1);
            check("clr_addr", 32'(ram_addr), 32'(i));
            check("clr_din", 32'(ram_din), 0);
            check("clr_init_done", 32'(init_done), 0);
            check("clr_resp_valid", 32'(bus.resp_valid), 0);
        end
        @(negedge clock);
        check("init_done_up", 32'(init_done), 1);
        check("ready_lag", 32'(bus.req_ready), 0);
        @(negedge clock);
        check("ready_up", 32'(bus.req_ready), 1);
        for (int i = 0; i < DEPTH; i++) check("clr_mem", 32'(mem[i]), 0);
        clear_model();
    endtask

    task automatic do_req(input logic [14:0] addr, input logic wr);
        int          cyc;
        int          base;
        logic [2:0]  idx;
        logic [11:0] tag;
        bit          e_hit, e_evict, e_we;
        logic [11:0] e_etag;
        idx     = addr[2:0];
        tag     = addr[14:3];
        e_hit   = m_valid[idx] && (m_tag[idx] == tag);
        e_evict = !e_hit && m_valid[idx] && m_dirty[idx];
        e_etag  = e_evict ? m_tag[idx] : 12'h000;
        e_we    = !e_hit || (wr && !m_dirty[idx]);
        if (!e_hit) begin
            m_valid[idx] = 1;
            m_dirty[idx] = wr;
            m_tag[idx]   = tag;
        end else if (wr) begin
            m_dirty[idx] = 1;
        end

        cyc = 0;
        @(negedge clock);
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        base = wr_total;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!bus.resp_valid && cyc < 10);
        check("resp_latency", 32'(cyc), 2);
        if (!bus.resp_valid) return;
        check("resp_hit", 32'(bus.resp_hit), 32'(e_hit));
        check("resp_evict", 32'(bus.resp_evict), 32'(e_evict));
        check("resp_evict_tag", 32'(bus.resp_evict_tag), 32'(e_etag));
        check("tag_writes", 32'(wr_total - base), 32'(e_we));
        check("mem_entry", 32'(mem[idx]), 32'({m_valid[idx], m_dirty[idx], m_tag[idx]}));
        @(negedge clock);
        check("resp_pulse", 32'(bus.resp_valid), 0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        wr_total      = 0;
        last_din      = '0;
        rd_addr       = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DWIDTH'($urandom);
        clear_model();

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_init();

        do_req({12'h05A, 3'd3}, 1'b0);
        check("din_read_miss", 32'(last_din), 32'h205A);
        do_req({12'h05A, 3'd3}, 1'b0);
        do_req({12'h05A, 3'd3}, 1'b1);
        check("din_write_hit", 32'(last_din), 32'h305A);
        do_req({12'h05A, 3'd3}, 1'b1);
        do_req({12'h0B1, 3'd3}, 1'b1);
        check("din_evict", 32'(last_din), 32'h30B1);
        do_req({12'h0C3, 3'd2}, 1'b0);
        do_req({12'h0B1, 3'd2}, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [14:0] a;
            a = {12'(12'h100 + $urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_req(a, 1'($urandom_range(0, 1)));
        end

        // Reset landing in LOOKUP drops the request and restarts the sweep
        @(negedge clock);
        begin
            int cyc;
            cyc = 0;
            while (!bus.req_ready && cyc < 20) begin
                @(negedge clock);
                cyc++;
            end
            check("ready_before_abort", 32'(bus.req_ready), 1);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = {12'h0EE, 3'd5};
        bus.req_write = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_init_done", 32'(init_done), 0);
        check_init();

        for (int n = 0; n < 20; n++) begin
            do_req({12'(12'h0EE + $urandom_range(0, 1)), 3'($urandom_range(4, 5))},
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
